// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART frame controller
package uart_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_PAY,
        S_CHK,
        S_DRAIN
    } state_t;

    localparam logic [7:0] UART_SYNC_DEFAULT = 8'hA5;

    function automatic logic len_in_range(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload register file, one sync write port, one async read port
module uart_frame_buf #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    // No reset: contents are only ever read after a full frame has been written.
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - parses SYNC/LEN/payload/CHK frames and drains validated payload
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SYNC_BYTE     = UART_SYNC_DEFAULT,
    parameter int         TIMEOUT_TICKS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_tmo,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    state_t          state;
    logic [7:0]      len;
    logic [7:0]      sum;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   rd;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      rd_data;
    logic [7:0]      len_m1;
    logic            idx_last;
    logic            rd_last;
    logic            tmo_armed;
    logic            tmo_fire;
    logic            handshake;

    assign len_m1    = len - 8'd1;
    assign idx_last  = (8'(idx) == len_m1);
    assign rd_last   = (8'(rd) == len_m1);
    assign tmo_armed = (state == S_LEN) || (state == S_PAY) || (state == S_CHK);
    // A byte arriving on the expiry tick wins over the timeout.
    assign tmo_fire  = tmo_armed && tick && !rx_done && (tmo_cnt == TMO_LAST);
    assign handshake = m_valid && m_ready;

    assign m_data = m_valid ? rd_data : 8'h00;
    assign m_last = m_valid && rd_last;
    assign busy   = (state != S_SYNC);

    uart_frame_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .wr_en   ((state == S_PAY) && rx_done),
        .wr_addr (idx),
        .wr_data (rx_data),
        .rd_addr (rd),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_SYNC;
            len      <= 8'd0;
            sum      <= 8'd0;
            idx      <= '0;
            rd       <= '0;
            tmo_cnt  <= '0;
            m_valid  <= 1'b0;
            frame_ok <= 1'b0;
            err_chk  <= 1'b0;
            err_len  <= 1'b0;
            err_tmo  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            frame_ok <= 1'b0;
            err_chk  <= 1'b0;
            err_len  <= 1'b0;
            err_tmo  <= 1'b0;

            // Every entry into a timed state happens on rx_done, which already clears the count.
            if (rx_done || !tmo_armed) begin
                tmo_cnt <= '0;
            end else if (tick) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                S_SYNC: begin
                    if (rx_done && rx_data == SYNC_BYTE) begin
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (rx_done) begin
                        len <= rx_data;
                        sum <= rx_data;
                        idx <= '0;
                        if (len_in_range(rx_data, MAX_LEN)) begin
                            state <= S_PAY;
                        end else begin
                            err_len <= 1'b1;
                            state   <= S_SYNC;
                        end
                    end
                end
                S_PAY: begin
                    if (rx_done) begin
                        sum <= sum + rx_data;
                        if (idx_last) begin
                            state <= S_CHK;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_CHK: begin
                    if (rx_done) begin
                        if (8'(sum + rx_data) == 8'h00) begin
                            frame_ok <= 1'b1;
                            m_valid  <= 1'b1;
                            rd       <= '0;
                            state    <= S_DRAIN;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= S_SYNC;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rx_done && drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                    if (handshake) begin
                        if (rd_last) begin
                            m_valid <= 1'b0;
                            state   <= S_SYNC;
                        end else begin
                            rd <= rd + 1'b1;
                        end
                    end
                end
                default: state <= S_SYNC;
            endcase

            if (tmo_fire) begin
                err_tmo <= 1'b1;
                state   <= S_SYNC;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_tmo;
    logic [7:0] drop_cnt;
    logic       busy;
    logic [22:0] outs;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(
        .MAX_LEN       (16),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_TICKS (30)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .frame_ok (frame_ok),
        .err_chk  (err_chk),
        .err_len  (err_len),
        .err_tmo  (err_tmo),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    assign outs = {m_valid, m_last, frame_ok, err_chk, err_len, err_tmo, busy, m_data, drop_cnt};

    typedef struct {
        int           nb;
        logic [159:0] b;
        int           e_ok;
        int           e_chk;
        int           e_len;
        int           npay;
        logic [127:0] p;
    } vec_t;

    vec_t tbl [8];

    int checks = 0;
    int passed = 0;
    int n_ok = 0, n_chk = 0, n_len = 0, n_tmo = 0, n_excl = 0;
    int b_ok, b_chk, b_len, b_tmo;
    logic [8:0] act_q [$];
    logic [8:0] exp_q [$];

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (m_valid && m_ready) act_q.push_back({m_last, m_data});
            n_ok  += int'(frame_ok);
            n_chk += int'(err_chk);
            n_len += int'(err_len);
            n_tmo += int'(err_tmo);
            if (int'(frame_ok) + int'(err_chk) + int'(err_len) + int'(err_tmo) > 1) n_excl++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        rx_data = v;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic do_tick();
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic snap();
        b_ok = n_ok; b_chk = n_chk; b_len = n_len; b_tmo = n_tmo;
    endtask

    task automatic settle(input string nm);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        check({nm, " idle"}, busy, 0);
    endtask

    task automatic check_deltas(input string nm, input int eok, input int echk, input int elen, input int etmo);
        check({nm, " frame_ok"}, n_ok - b_ok, eok);
        check({nm, " err_chk"}, n_chk - b_chk, echk);
        check({nm, " err_len"}, n_len - b_len, elen);
        check({nm, " err_tmo"}, n_tmo - b_tmo, etmo);
    endtask

    task automatic push_pay(input int npay, input logic [127:0] p);
        for (int i = 0; i < npay; i++) exp_q.push_back({i == npay - 1, p[8*(npay-1-i) +: 8]});
    endtask

    task automatic compare_drain(input string nm);
        logic [8:0] e;
        logic [8:0] a;
        int k;
        k = 0;
        check({nm, " beats"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : 9'bx;
            check($sformatf("%s beat%0d {last,data}", nm, k), a, e);
            k++;
        end
        act_q.delete();
    endtask

    task automatic drive_vec(input string nm, input vec_t v);
        snap();
        push_pay(v.npay, v.p);
        for (int i = 0; i < v.nb; i++) send_byte(v.b[8*(v.nb-1-i) +: 8]);
        settle(nm);
        check_deltas(nm, v.e_ok, v.e_chk, v.e_len, 0);
        compare_drain(nm);
    endtask

    initial begin
        tbl[0] = '{5,  160'hA5_02_10_20_CE, 1, 0, 0, 2, 128'h10_20};
        tbl[1] = '{5,  160'hA5_02_10_20_CF, 0, 1, 0, 0, 128'h0};
        tbl[2] = '{5,  160'hA5_02_10_20_CE, 1, 0, 0, 2, 128'h10_20};
        tbl[3] = '{2,  160'hA5_00,          0, 0, 1, 0, 128'h0};
        tbl[4] = '{2,  160'hA5_11,          0, 0, 1, 0, 128'h0};
        tbl[5] = '{5,  160'h33_A5_01_7F_80, 1, 0, 0, 1, 128'h7F};
        tbl[6] = '{4,  160'hA5_01_FF_00,    1, 0, 0, 1, 128'hFF};
        tbl[7] = '{19, 160'hA5_10_01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10_68, 1, 0, 0, 16,
                   128'h01_02_03_04_05_06_07_08_09_0A_0B_0C_0D_0E_0F_10};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("reset outputs", 32'(outs), 0);

        for (int v = 0; v < 8; v++) drive_vec($sformatf("vec%0d", v), tbl[v]);

        // inter-byte timeout expires on the 30th tick
        snap();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        repeat (29) do_tick();
        @(posedge clk); #1;
        check("tmo 29 ticks err_tmo", n_tmo - b_tmo, 0);
        check("tmo 29 ticks busy", busy, 1);
        do_tick();
        repeat (2) @(posedge clk);
        #1;
        check("tmo 30 ticks err_tmo", n_tmo - b_tmo, 1);
        check("tmo 30 ticks busy", busy, 0);
        check("tmo no payload", act_q.size(), 0);

        // byte on the expiry tick wins
        snap();
        push_pay(3, 128'h01_02_03);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        repeat (29) do_tick();
        @(posedge clk); #1;
        tick = 1'b1; rx_done = 1'b1; rx_data = 8'h02;
        @(posedge clk); #1;
        tick = 1'b0; rx_done = 1'b0;
        @(posedge clk); #1;
        check("tmo race err_tmo", n_tmo - b_tmo, 0);
        check("tmo race busy", busy, 1);
        send_byte(8'h03); send_byte(8'hF7);
        settle("tmo race");
        check_deltas("tmo race", 1, 0, 0, 0);
        compare_drain("tmo race");

        // drain backpressure with dropped bytes
        m_ready = 1'b0;
        snap();
        push_pay(2, 128'h10_20);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hCE);
        repeat (3) @(posedge clk);
        #1;
        check("bp m_valid", m_valid, 1);
        check("bp m_data held", m_data, 8'h10);
        check("bp m_last", m_last, 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(posedge clk); #1;
        check("bp drop_cnt", drop_cnt, 3);
        check("bp m_data after drops", m_data, 8'h10);
        m_ready = 1'b1;
        settle("bp");
        check_deltas("bp", 1, 0, 0, 0);
        compare_drain("bp");

        // reset in the middle of the payload
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
        pulse_reset();
        check("reset in pay outputs", 32'(outs), 0);
        drive_vec("after pay reset", tbl[0]);

        // reset in the middle of a stalled drain
        m_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'hCE);
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset drain m_valid", m_valid, 1);
        pulse_reset();
        check("reset in drain outputs", 32'(outs), 0);
        act_q.delete();
        m_ready = 1'b1;
        drive_vec("after drain reset", tbl[0]);

        check("pulse exclusivity", n_excl, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
